cm85_serial_cascade: RTL

- Sequential, slice-by-slice magnitude comparator built on the 74x85 cascade model.
- Accepts two WIDTH-bit operands through a valid/ready handshake and walks them SLICE bits per cycle, LSB slice first.
- Each slice's less/equal/greater result feeds the next, more significant slice as its cascade input, as in a 74x85 cascade chain.
- Used where a wide comparator is too costly and a WIDTH/SLICE-cycle latency is acceptable.

---
 rtl/cm85_serial_cascade.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cm85_serial_cascade.sv
// Purpose: serial magnitude comparator, 74x85 cascade model, SLICE bits per cycle, LSB slice first.
// Latency: result valid NSLICE+1 edges after the accept edge (slice compare is registered before it updates the flags).
// Backpressure: single outstanding job; in_ready low while busy, result held in DONE until out_ready.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready + a_in/b_in/casc_{lt,eq,gt} operand handshake;
//        out_valid/out_ready + lt_out/eq_out/gt_out result handshake; busy high in RUN or DONE.
module cm85_serial_cascade #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             casc_lt,
    input  logic             casc_eq,
    input  logic             casc_gt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt_out,
    output logic             eq_out,
    output logic             gt_out,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [IW-1:0]    idx;
    logic             rl, re, rg;          // running flags
    logic             nl, ne, ng;          // running flags after the pending slice result
    logic             cl, ce, cg;          // resolved cascade-in
    logic             cmp_vld, cmp_lt, cmp_gt, cmp_last;
    logic             issued_all;          // every slice has been sent to the compare stage
    logic [SLICE-1:0] sa, sb;

    // Cascade-in is resolved to one-hot with priority eq > gt > lt; all-zero counts as eq.
    always_comb begin
        ce = casc_eq | ~(casc_gt | casc_lt);
        cg = ~casc_eq & casc_gt;
        cl = ~casc_eq & ~casc_gt & casc_lt;
    end

    always_comb begin
        sa = a_reg[idx*SLICE +: SLICE];
        sb = b_reg[idx*SLICE +: SLICE];
    end

    // A differing slice overwrites the flags; higher slices are applied later, so the
    // most significant differing slice wins.
    always_comb begin
        nl = rl;
        ne = re;
        ng = rg;
        if (cmp_vld && cmp_gt) begin
            nl = 1'b0; ne = 1'b0; ng = 1'b1;
        end else if (cmp_vld && cmp_lt) begin
            nl = 1'b1; ne = 1'b0; ng = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cmp_vld && cmp_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            idx        <= '0;
            rl         <= 1'b0;
            re         <= 1'b1;
            rg         <= 1'b0;
            cmp_vld    <= 1'b0;
            cmp_lt     <= 1'b0;
            cmp_gt     <= 1'b0;
            cmp_last   <= 1'b0;
            issued_all <= 1'b0;
            lt_out     <= 1'b0;
            eq_out     <= 1'b1;
            gt_out     <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_reg      <= a_in;
                b_reg      <= b_in;
                rl         <= cl;
                re         <= ce;
                rg         <= cg;
                idx        <= '0;
                cmp_vld    <= 1'b0;
                issued_all <= 1'b0;
            end
        end else if (state == RUN) begin
            rl <= nl;
            re <= ne;
            rg <= ng;
            // Result outputs only move when the final slice lands, so they hold outside DONE.
            if (cmp_vld && cmp_last) begin
                lt_out <= nl;
                eq_out <= ne;
                gt_out <= ng;
            end
            if (!issued_all) begin
                cmp_vld  <= 1'b1;
                cmp_lt   <= (sa < sb);
                cmp_gt   <= (sa > sb);
                cmp_last <= (idx == LAST);
                if (idx == LAST) issued_all <= 1'b1;
                else             idx        <= idx + 1'b1;
            end else begin
                cmp_vld <= 1'b0;
            end
        end
    end

endmodule
